// File: rtl/maxdata_axil_pkg.sv
// rtl/maxdata_axil_pkg.sv - shared constants, FSM state types and strobe merge for the AXI4-Lite register slave
package maxdata_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE      = 2'd0,
    W_HAVE_ADDR = 2'd1,
    W_HAVE_DATA = 2'd2,
    W_RESP      = 2'd3
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_e;

  // Byte-lane merge: lanes with a set strobe take the new byte, others keep the old one.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/maxdata_axil_rd_chan.sv
// rtl/maxdata_axil_rd_chan.sv - AXI4-Lite read channel: AR accept, registered rdata mux, R hold
import maxdata_axil_pkg::*;

module maxdata_axil_rd_chan #(
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     init_done,
  input  logic [ADDR_WIDTH-1:0]    araddr,
  input  logic                     arvalid,
  output logic                     arready,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [31:0]              rdata,
  output logic [1:0]               rresp,
  input  logic [NUM_REGS*32-1:0]   regs_flat
);

  rd_state_e   state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] ridx;

  // Byte offset bits never select anything; unaligned reads hit the containing word.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^araddr[1:0];

  assign ridx    = 32'(araddr[ADDR_WIDTH-1:2]);
  assign arready = init_done && (state_q == R_IDLE);
  assign rvalid  = (state_q == R_RESP);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

  // Next-state and captured read data; the mux samples registers before any same-edge write lands.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    case (state_q)
      R_IDLE: begin
        if (arvalid && arready) begin
          state_d = R_RESP;
          rdata_d = '0;
          rresp_d = RESP_SLVERR;
          for (int i = 0; i < NUM_REGS; i++) begin
            if (ridx == 32'(i)) begin
              rdata_d = regs_flat[32*i +: 32];
              rresp_d = RESP_OKAY;
            end
          end
        end
      end
      R_RESP: begin
        if (rready) begin
          state_d = R_IDLE;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  // Read channel state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= R_IDLE;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
    end
  end

endmodule

// File: rtl/maxdata_axil_slave_regs.sv
// rtl/maxdata_axil_slave_regs.sv - AXI4-Lite slave register file with write FSM, register array and write pulses
import maxdata_axil_pkg::*;

module maxdata_axil_slave_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int NUM_REGS           = 4
) (
  input  logic                                s00_axi_aclk,
  input  logic                                s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]       s00_axi_awaddr,
  input  logic [2:0]                          s00_axi_awprot,
  input  logic                                s00_axi_awvalid,
  output logic                                s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]     s00_axi_wstrb,
  input  logic                                s00_axi_wvalid,
  output logic                                s00_axi_wready,
  output logic [1:0]                          s00_axi_bresp,
  output logic                                s00_axi_bvalid,
  input  logic                                s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]       s00_axi_araddr,
  input  logic [2:0]                          s00_axi_arprot,
  input  logic                                s00_axi_arvalid,
  output logic                                s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       s00_axi_rdata,
  output logic [1:0]                          s00_axi_rresp,
  output logic                                s00_axi_rvalid,
  input  logic                                s00_axi_rready,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]                 reg_wr_pulse
);

  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

  logic                  init_done_q, init_done_d;
  wr_state_e             wstate_q, wstate_d;
  logic [IDX_W-1:0]      widx_q, widx_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [NUM_REGS-1:0]   pulse_q, pulse_d;
  logic [31:0]           regs_q [NUM_REGS];
  logic [31:0]           regs_d [NUM_REGS];

  logic                  aw_hs, w_hs, complete;
  logic [IDX_W-1:0]      cur_idx;
  logic [31:0]           cur_idx_ext;
  logic [31:0]           cur_data;
  logic [3:0]            cur_strb;
  logic                  in_range;

  // Protection bits and address byte offset carry no meaning for this register file.
  logic unused_inputs;
  assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0]};

  assign s00_axi_awready = init_done_q && ((wstate_q == W_IDLE) || (wstate_q == W_HAVE_DATA));
  assign s00_axi_wready  = init_done_q && ((wstate_q == W_IDLE) || (wstate_q == W_HAVE_ADDR));
  assign s00_axi_bvalid  = (wstate_q == W_RESP);
  assign s00_axi_bresp   = bresp_q;
  assign reg_wr_pulse    = pulse_q;

  assign aw_hs = s00_axi_awvalid && s00_axi_awready;
  assign w_hs  = s00_axi_wvalid && s00_axi_wready;

  // The completing beat may arrive on either channel, so take whichever side is live this cycle.
  assign cur_idx     = aw_hs ? s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2] : widx_q;
  assign cur_data    = w_hs ? s00_axi_wdata : wdata_q;
  assign cur_strb    = w_hs ? s00_axi_wstrb : wstrb_q;
  assign cur_idx_ext = 32'(cur_idx);
  assign in_range    = (cur_idx_ext < 32'(NUM_REGS));

  generate
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign reg_q[32*g +: 32] = regs_q[g];
    end
  endgenerate

  // Write FSM next state, AW/W latching, register update and pulse generation.
  always_comb begin
    init_done_d = 1'b1;
    wstate_d    = wstate_q;
    widx_d      = widx_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    bresp_d     = bresp_q;
    pulse_d     = '0;
    complete    = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end

    if (aw_hs) begin
      widx_d = s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    end
    if (w_hs) begin
      wdata_d = s00_axi_wdata;
      wstrb_d = s00_axi_wstrb;
    end

    case (wstate_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          complete = 1'b1;
        end else if (aw_hs) begin
          wstate_d = W_HAVE_ADDR;
        end else if (w_hs) begin
          wstate_d = W_HAVE_DATA;
        end
      end
      W_HAVE_ADDR: begin
        if (w_hs) begin
          complete = 1'b1;
        end
      end
      W_HAVE_DATA: begin
        if (aw_hs) begin
          complete = 1'b1;
        end
      end
      W_RESP: begin
        if (s00_axi_bready) begin
          wstate_d = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase

    if (complete) begin
      wstate_d = W_RESP;
      bresp_d  = in_range ? RESP_OKAY : RESP_SLVERR;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (in_range && (cur_idx_ext == 32'(i))) begin
          regs_d[i]  = strb_merge(regs_q[i], cur_data, cur_strb);
          pulse_d[i] = 1'b1;
        end
      end
    end
  end

  // Write-side state, register array and init_done flop.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      init_done_q <= 1'b0;
      wstate_q    <= W_IDLE;
      widx_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      bresp_q     <= RESP_OKAY;
      pulse_q     <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      init_done_q <= init_done_d;
      wstate_q    <= wstate_d;
      widx_q      <= widx_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      bresp_q     <= bresp_d;
      pulse_q     <= pulse_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  maxdata_axil_rd_chan #(
    .ADDR_WIDTH (C_S_AXI_ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_rd_chan (
    .clk       (s00_axi_aclk),
    .rst_n     (s00_axi_aresetn),
    .init_done (init_done_q),
    .araddr    (s00_axi_araddr),
    .arvalid   (s00_axi_arvalid),
    .arready   (s00_axi_arready),
    .rvalid    (s00_axi_rvalid),
    .rready    (s00_axi_rready),
    .rdata     (s00_axi_rdata),
    .rresp     (s00_axi_rresp),
    .regs_flat (reg_q)
  );

endmodule
